cdb_wb_arbiter: RTL
===================

// Module: cdb_wb_arbiter
// PURPOSE
//  Shares one result/common-data-bus (CDB) writeback port between the ALU, branch and mem FUs.
//  Sits between fus and phys_reg_file / dispatch wakeup / ROB completion.
//  - Buffers one completed result per FU and grants the bus round-robin.
//  - Squashes buffered results younger than a branch mispredict.
// PARAMETERS
//  NUM_REQ  3   requesters; index 0=ALU, 1=branch, 2=mem
//  PREG_W   7   physical register tag width
//  ROB_W    5   ROB tag width (ROB depth 2**ROB_W)
//  DATA_W   32  result data width
// PORTS
//  clk             in   1               clock; all state updates on posedge
//  reset           in   1               synchronous, active-low (reset==0 resets)
//  req_valid       in   NUM_REQ         FU result valid, one bit per requester
//  req_ready       out  NUM_REQ         arbiter can accept a result this cycle
//  req_preg        in   NUM_REQ*PREG_W  destination preg, per requester
//  req_data        in   NUM_REQ*DATA_W  result data, per requester
//  req_rob_tag     in   NUM_REQ*ROB_W   ROB tag of the result, per requester
//  rob_head        in   ROB_W           oldest in-flight ROB tag (age reference)
//  mispredict      in   1               branch mispredict flush this cycle
//  mispredict_tag  in   ROB_W           ROB tag of the mispredicting branch
//  cdb_valid       out  1               CDB carries a result this cycle
//  cdb_preg        out  PREG_W          CDB destination preg
//  cdb_data        out  DATA_W          CDB result data
//  cdb_rob_tag     out  ROB_W           CDB ROB tag
//  cdb_req_id      out  2               index of the granted requester
// BEHAVIOUR
//  Storage
//  - One holding slot per requester: full bit + preg/data/tag.
//  - A round-robin pointer rr_ptr, range 0..NUM_REQ-1.
//  Reset (reset==0 at posedge)
//  - All slots empty; rr_ptr=0.
//  - While reset==0: req_ready=0, cdb_valid=0, cdb_preg/data/tag/req_id=0.
//  - Reset applied mid-operation discards every held result; no CDB output the next cycle.
//  Accept
//  - req_ready[i] = reset & (!full[i] | grant[i]).
//  - On valid&ready the slot loads at the posedge.
//  - A slot granted in the same cycle is refilled without a bubble.
//  Grant (combinational from registered slots)
//  - Winner is the first full slot scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//  - cdb_* shows the winner's fields; cdb_valid=1 iff a winner exists and is not squashed.
//  - On grant of i: slot i is cleared at the posedge and rr_ptr <= (i+1) mod NUM_REQ.
//  - With no grant, rr_ptr holds.
//  - When cdb_valid=0, cdb_preg/data/tag/req_id are driven to 0.
//  Latency and throughput
//  - Result accepted at edge k appears on the CDB during cycle k+1 at the earliest.
//  - One result per cycle sustained.
//  - A full slot is granted within NUM_REQ cycles, so no requester starves.
//  Age and flush
//  - age(t) = (t - rob_head) mod 2**ROB_W; the ROB_W-bit subtraction wraps naturally.
//  - t is younger than the branch iff age(t) > age(mispredict_tag).
//  - The branch's own tag is never squashed.
//  - In a mispredict cycle every younger full slot clears at the posedge.
//  - In that cycle a younger winner has cdb_valid masked to 0, and rr_ptr does not advance for it.
//  - Younger incoming requests still see req_ready=1 and are dropped, not stored.
//  - Older slots are unaffected and are granted normally, including in the same cycle.
//  Assertions
//  - Slot full ∧ req_valid ∧ !req_ready is legal: the FU holds its data.
//  - cdb_req_id is always < NUM_REQ when cdb_valid=1.
// STRUCTURE
//  - In types_pkg: typedef cdb_data {preg, data, rob_tag}.
//  - In types_pkg: function rob_younger(tag, ref, head) and the constants NUM_FU=3, FU_ALU/FU_B/FU_MEM ids.
//  - Sub-module rr_arbiter #(N): combinational one-hot round-robin pick from a request vector and rr_ptr.
//  - Slots, rr_ptr update and flush logic live in cdb_wb_arbiter.
// TESTING
//  1. Reset: reset=0 for 2 cycles with req_valid=3'b111
//     -> req_ready=0, cdb_valid=0 throughout; after release req_ready=3'b111.
//  2. Single result: ALU preg=12, data=32'hDEAD_BEEF, tag=3 at edge k
//     -> cycle k+1 cdb_valid=1, preg=12, data=DEAD_BEEF, tag=3, req_id=0; cycle k+2 cdb_valid=0.
//  3. Simultaneous: all three valid at edge k, rr_ptr=0
//     -> req_id 0,1,2 on cycles k+1..k+3; req_ready[2]=0 in k+1 and k+2 while its new req_valid held.
//  4. Fairness: ALU and branch valid every cycle
//     -> CDB alternates req_id 0,1,0,1,...; cdb_valid=1 every cycle.
//  5. Wrap flush: rob_head=30, slots hold ALU tag=30 and mem tag=1, mispredict=1 with mispredict_tag=31
//     -> ALU tag 30 delivered; tag 1 never appears on the CDB.
//  6. Reset mid-run: two slots full, reset=0 for 1 cycle
//     -> cdb_valid=0 next cycle; after release no stale result is emitted.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types and helpers for the CDB writeback arbiter: FU ids, the
// result payload struct and the ROB age comparison used for flush.
package types_pkg;

  localparam int NUM_FU = 3;
  localparam int FU_ALU = 0;
  localparam int FU_B   = 1;
  localparam int FU_MEM = 2;

  localparam int PREG_W_DEF = 7;
  localparam int ROB_W_DEF  = 5;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [PREG_W_DEF-1:0] preg;
    logic [DATA_W_DEF-1:0] data;
    logic [ROB_W_DEF-1:0]  rob_tag;
  } cdb_data_t;

  // True when tag is strictly younger than ref_tag. Ages are measured from the
  // ROB head and wrap at 2**w, so the subtraction is masked to w bits.
  function automatic logic rob_younger(input logic [31:0] tag,
                                       input logic [31:0] ref_tag,
                                       input logic [31:0] head,
                                       input int unsigned w);
    logic [31:0] mask;
    logic [31:0] age_t;
    logic [31:0] age_r;
    mask  = (32'd1 << w) - 32'd1;
    age_t = (tag - head) & mask;
    age_r = (ref_tag - head) & mask;
    return age_t > age_r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request scanning from ptr
// upward with wrap-around is granted, as a one-hot vector.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;

  // Scan priority positions ptr, ptr+1, ... and grant the first requester seen.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_wb_arbiter.sv
// Shares the single CDB writeback port between the ALU, branch and mem FUs.
// Each FU owns one holding slot; full slots are granted round-robin, and
// results younger than a mispredicting branch are squashed.
//
// Handshake: an FU result transfers on a posedge where req_valid[i] and
// req_ready[i] are both high. While req_valid[i] is high and req_ready[i] is
// low the FU must hold preg/data/tag stable. The CDB side has no back-pressure:
// cdb_valid high means the result is consumed that cycle.
module cdb_wb_arbiter
  import types_pkg::*;
#(
  parameter int NUM_REQ = NUM_FU,
  parameter int PREG_W  = PREG_W_DEF,
  parameter int ROB_W   = ROB_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*PREG_W-1:0] req_preg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob_tag,
  input  logic [ROB_W-1:0]          rob_head,
  input  logic                      mispredict,
  input  logic [ROB_W-1:0]          mispredict_tag,
  output logic                      cdb_valid,
  output logic [PREG_W-1:0]         cdb_preg,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [ROB_W-1:0]          cdb_rob_tag,
  output logic [1:0]                cdb_req_id
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_ID = PTR_W'(NUM_REQ - 1);

  // Holding slots
  logic [NUM_REQ-1:0]             full;
  logic [NUM_REQ-1:0][PREG_W-1:0] slot_preg;
  logic [NUM_REQ-1:0][DATA_W-1:0] slot_data;
  logic [NUM_REQ-1:0][ROB_W-1:0]  slot_tag;
  logic [PTR_W-1:0]               rr_ptr;

  // Arbitration and flush signals
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] slot_young;
  logic [NUM_REQ-1:0] in_young;
  logic [NUM_REQ-1:0] accept;
  logic [PTR_W-1:0]   win_id;
  logic [PREG_W-1:0]  win_preg;
  logic [DATA_W-1:0]  win_data;
  logic [ROB_W-1:0]   win_tag;
  logic               win_squash;
  logic               deliver;

  rr_arbiter #(.N(NUM_REQ), .PW(PTR_W)) u_rr (
    .req (full),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  // Flag held and incoming results that are younger than a mispredicting branch.
  always_comb begin
    slot_young = '0;
    in_young   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_young[i] = mispredict &
                      rob_younger(32'(slot_tag[i]), 32'(mispredict_tag),
                                  32'(rob_head), ROB_W);
      in_young[i]   = mispredict &
                      rob_younger(32'(req_rob_tag[i*ROB_W +: ROB_W]),
                                  32'(mispredict_tag), 32'(rob_head), ROB_W);
    end
  end

  // Select the winning slot's index and payload from the one-hot pick.
  always_comb begin
    win_id   = '0;
    win_preg = '0;
    win_data = '0;
    win_tag  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        win_id   = PTR_W'(i);
        win_preg = slot_preg[i];
        win_data = slot_data[i];
        win_tag  = slot_tag[i];
      end
    end
  end

  // A squashed winner is not a grant: it is dropped and rr_ptr stays put.
  assign win_squash = |(pick & slot_young);
  assign deliver    = reset & (|pick) & ~win_squash;
  assign grant      = pick & {NUM_REQ{deliver}};
  assign req_ready  = {NUM_REQ{reset}} & (~full | grant);
  assign accept     = req_valid & req_ready;

  assign cdb_valid   = deliver;
  assign cdb_preg    = deliver ? win_preg : '0;
  assign cdb_data    = deliver ? win_data : '0;
  assign cdb_rob_tag = deliver ? win_tag : '0;
  assign cdb_req_id  = deliver ? 2'(win_id) : 2'd0;

  // Slot occupancy: load on accept (unless the result is already squashed),
  // clear on grant or flush.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          full[i] <= ~in_young[i];
        end else if (grant[i] | slot_young[i]) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Slot payload capture; contents are only meaningful while the slot is full.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i] & ~in_young[i]) begin
        slot_preg[i] <= req_preg[i*PREG_W +: PREG_W];
        slot_data[i] <= req_data[i*DATA_W +: DATA_W];
        slot_tag[i]  <= req_rob_tag[i*ROB_W +: ROB_W];
      end
    end
  end

  // Round-robin pointer moves just past the requester that used the bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (deliver) begin
      rr_ptr <= (win_id == LAST_ID) ? '0 : win_id + PTR_W'(1);
    end
  end

endmodule
